// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, nop encoding, next-PC select codes and
// the fetch FSM state type.
package cpu_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam logic [1:0] PCSRC_PC4   = 2'd0;
  localparam logic [1:0] PCSRC_NPCB  = 2'd1;
  localparam logic [1:0] PCSRC_NPCJ  = 2'd2;
  localparam logic [1:0] PCSRC_NPCJR = 2'd3;

  typedef enum logic {
    NORMAL = 1'b0,
    PEND   = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Redirect target mux: picks the branch, jump or register-jump target
// selected by the decode stage.
module npc_sel
  import cpu_pkg::*;
(
  input  logic [1:0]  pcsrc_D,
  input  logic [31:0] npcb,
  input  logic [31:0] npcj,
  input  logic [31:0] npcjr,
  output logic [31:0] target
);

  // PCSRC_PC4 never redirects, so its target value is irrelevant
  always_comb begin
    target = '0;
    case (pcsrc_D)
      PCSRC_NPCB:  target = npcb;
      PCSRC_NPCJ:  target = npcj;
      PCSRC_NPCJR: target = npcjr;
      default:     target = '0;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, branch-delay-slot semantics and
// a pending-redirect state for redirects that arrive while memory is not ready.
module if_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic [1:0]  pcsrc_D,
  input  logic [31:0] npcb,
  input  logic [31:0] npcj,
  input  logic [31:0] npcjr,
  input  logic [31:0] im_rdata,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic        im_req,
  output logic [31:0] instr_D,
  output logic [31:0] pc4_D,
  output logic        valid_D
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc4_F, pend_target, target;
  logic         fire_F, redirect_D;

  npc_sel u_npc_sel (
    .pcsrc_D (pcsrc_D),
    .npcb    (npcb),
    .npcj    (npcj),
    .npcjr   (npcjr),
    .target  (target)
  );

  assign fire_F     = im_ready && !stall_D;
  assign redirect_D = valid_D && !stall_D && (pcsrc_D != PCSRC_PC4);
  assign pc4_F      = pc + 32'd4;
  assign im_addr    = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= NORMAL;
    else        state <= state_next;
  end

  // A redirect that misses the fetch leaves the delay slot still to be
  // fetched, so the target is parked until that fetch fires.
  always_comb begin
    state_next = state;
    pc_next    = pc4_F;
    case (state)
      NORMAL: if (redirect_D && !fire_F) state_next = PEND;
      PEND:   if (fire_F) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
    if (redirect_D)        pc_next = target;
    else if (state == PEND) pc_next = pend_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= PC_RESET;
      pend_target <= '0;
      instr_D     <= NOP;
      pc4_D       <= '0;
      valid_D     <= 1'b0;
      im_req      <= 1'b0;
    end else begin
      im_req <= 1'b1;
      if (fire_F) pc <= align_word(pc_next);
      if (state == NORMAL && redirect_D && !fire_F) pend_target <= align_word(target);
      if (!stall_D) begin
        instr_D <= im_ready ? im_rdata : NOP;
        pc4_D   <= pc4_F;
        valid_D <= im_ready;
      end
    end
  end

  // While pending, decode always holds the bubble left behind by the redirect
  a_no_redirect_in_pend: assert property (
    @(posedge clk) disable iff (!reset) !(state == PEND && redirect_D)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: IF/ID contents and fetch addresses are
// predicted per cycle into scoreboards and compared as the stage updates.
module tb_if_stage;
  import cpu_pkg::*;

  logic        clk, reset, stall_D, im_ready, im_req, valid_D;
  logic [1:0]  pcsrc_D;
  logic [31:0] npcb, npcj, npcjr, im_rdata, im_addr, instr_D, pc4_D;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  ifid_t       sb_q[$];
  logic [31:0] cur_addr;
  logic        addr_chk;
  logic        mon_stall, mon_rst;

  if_stage dut (
    .clk      (clk),
    .reset    (reset),
    .stall_D  (stall_D),
    .pcsrc_D  (pcsrc_D),
    .npcb     (npcb),
    .npcj     (npcj),
    .npcjr    (npcjr),
    .im_rdata (im_rdata),
    .im_ready (im_ready),
    .im_addr  (im_addr),
    .im_req   (im_req),
    .instr_D  (instr_D),
    .pc4_D    (pc4_D),
    .valid_D  (valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return 32'hAC00_0000 ^ a;
  endfunction

  // Pop the predicted IF/ID contents on every unstalled edge out of reset
  always @(posedge clk) begin
    mon_stall = stall_D;
    mon_rst   = reset;
    #1;
    if (mon_rst && !mon_stall) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL ifid_unexpected_update: instr_D=%h pc4_D=%h valid_D=%b, no update expected",
                 instr_D, pc4_D, valid_D);
      end else begin
        ifid_t e;
        e = sb_q.pop_front();
        if (instr_D !== e.instr || pc4_D !== e.pc4 || valid_D !== e.valid) begin
          errors++;
          $display("[TB] FAIL ifid: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
                   instr_D, pc4_D, valid_D, e.instr, e.pc4, e.valid);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (addr_chk) begin
      checks++;
      if (im_addr !== cur_addr) begin
        errors++;
        $display("[TB] FAIL im_addr: got %h, expected %h", im_addr, cur_addr);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Drives one cycle; exp_addr is where the bench expects the PC to be
  task automatic apply_stimulus(input logic [31:0] exp_addr, input logic rdy,
                                input logic stl, input logic [1:0] src);
    ifid_t e;
    cur_addr = exp_addr;
    addr_chk = 1'b1;
    im_ready = rdy;
    stall_D  = stl;
    pcsrc_D  = src;
    im_rdata = rdy ? word_for(exp_addr) : 32'hDEAD_BEEF;
    if (!stl) begin
      e.instr = rdy ? word_for(exp_addr) : 32'h0;
      e.pc4   = exp_addr + 32'd4;
      e.valid = rdy;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_D = 1'b0; pcsrc_D = 2'd0; im_ready = 1'b1;
    im_rdata = 32'h1234_5678; npcb = '0; npcj = '0; npcjr = '0;
    addr_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (im_addr !== 32'h3000 || im_req !== 1'b0 || valid_D !== 1'b0 ||
        instr_D !== 32'h0 || pc4_D !== 32'h0 || dut.state !== NORMAL) begin
      errors++;
      $display("[TB] FAIL reset_values: addr=%h req=%b valid=%b instr=%h pc4=%h, expected 3000/0/0/0/0",
               im_addr, im_req, valid_D, instr_D, pc4_D);
    end
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    apply_stimulus(32'h3000, 1'b1, 1'b0, 2'd0);
    checks++;
    if (pc4_D !== 32'h3004 || im_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_fetch: pc4_D=%h im_req=%b, expected 3004/1", pc4_D, im_req);
    end
    apply_stimulus(32'h3004, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_branch();
    npcb = 32'h3040;
    apply_stimulus(32'h3008, 1'b1, 1'b0, 2'd1);
    checks++;
    if (valid_D !== 1'b1 || instr_D !== word_for(32'h3008)) begin
      errors++;
      $display("[TB] FAIL delay_slot: valid_D=%b instr_D=%h, expected 1/%h",
               valid_D, instr_D, word_for(32'h3008));
    end
    apply_stimulus(32'h3040, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_pend();
    npcj = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(32'h3044, 1'b0, 1'b0, 2'd2);
      checks++;
      if (dut.state !== PEND || valid_D !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pend_bubble[%0d]: state=%0d valid_D=%b, expected PEND/0",
                 i, dut.state, valid_D);
      end
    end
    apply_stimulus(32'h3044, 1'b1, 1'b0, 2'd0);
    checks++;
    if (dut.state !== NORMAL) begin
      errors++;
      $display("[TB] FAIL pend_exit: state=%0d, expected NORMAL", dut.state);
    end
    apply_stimulus(32'h3100, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_stall();
    npcjr = 32'h3500;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(32'h3104, 1'b1, 1'b1, 2'd3);
      checks++;
      if (instr_D !== word_for(32'h3100) || pc4_D !== 32'h3104 || valid_D !== 1'b1 ||
          dut.state !== NORMAL) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: instr=%h pc4=%h valid=%b, expected %h/3104/1",
                 i, instr_D, pc4_D, valid_D, word_for(32'h3100));
      end
    end
    apply_stimulus(32'h3104, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_jr_and_reset_in_pend();
    npcjr = 32'h3203;
    apply_stimulus(32'h3108, 1'b1, 1'b0, 2'd3);
    apply_stimulus(32'h3200, 1'b1, 1'b0, 2'd0);
    npcb = 32'h3300;
    apply_stimulus(32'h3204, 1'b0, 1'b0, 2'd1);
    checks++;
    if (dut.state !== PEND) begin
      errors++;
      $display("[TB] FAIL jr_pend_entry: state=%0d, expected PEND", dut.state);
    end
    addr_chk = 1'b0;
    reset = 1'b0;
    #3;
    checks++;
    if (im_addr !== 32'h3000 || dut.state !== NORMAL || valid_D !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_pend: addr=%h state=%0d valid=%b, expected 3000/NORMAL/0",
               im_addr, dut.state, valid_D);
    end
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply_stimulus(32'h3000, 1'b1, 1'b0, 2'd0);
    apply_stimulus(32'h3004, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_wrap();
    npcj = 32'hFFFF_FFFC;
    apply_stimulus(32'h3008, 1'b1, 1'b0, 2'd2);
    apply_stimulus(32'hFFFF_FFFC, 1'b1, 1'b0, 2'd0);
    checks++;
    if (pc4_D !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL wrap_pc4: pc4_D=%h, expected 00000000", pc4_D);
    end
    apply_stimulus(32'h0000_0000, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_pend();
    test_stall();
    test_jr_and_reset_in_pend();
    test_wrap();
    addr_chk = 1'b0;
    stall_D  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: the clock port is clk and the reset port is reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; when low, all state is forced to its reset value.
REQ-004 stall_D  input  1  hazard-unit stall; holds the PC and the IF/ID register.
REQ-005 pcsrc_D  input  2  next-PC select from the decode stage: 0 = pc+4, 1 = npcb, 2 = npcj, 3 = npcjr.
REQ-006 npcb, npcj, npcjr  input  32 each  branch, jump and register-jump targets from the decode stage.
REQ-007 im_rdata  input  32  instruction word from instruction memory.
REQ-008 im_ready  input  1  im_rdata is valid for im_addr this cycle.
REQ-009 im_addr  output  32  fetch address, equal to the current PC.
REQ-010 im_req  output  1  fetch request.
REQ-011 instr_D  output  32  IF/ID instruction register.
REQ-012 pc4_D  output  32  IF/ID PC+4 register.
REQ-013 valid_D  output  1  the IF/ID register holds a real instruction, not a bubble.

Function
REQ-014 The fetch fires (fire_F) when im_ready=1 and stall_D=0.
REQ-015 A redirect (redirect_D) occurs when valid_D=1, stall_D=0 and pcsrc_D≠0; the target is npcb, npcj or npcjr as selected by pcsrc_D.
REQ-016 The block SHALL keep branch-delay-slot semantics: the instruction fetched in the same cycle as a redirect is never squashed.
REQ-017 The FSM SHALL have two states: NORMAL and PEND. A redirect without fire_F moves NORMAL to PEND and latches the target into pend_target. fire_F moves PEND to NORMAL.
REQ-018 PC update on fire_F, in priority order:
  - redirect_D=1: PC <= target;
  - else state PEND: PC <= pend_target;
  - else: PC <= PC+4.
  Without fire_F, the PC holds.
REQ-019 The two low bits of every value loaded into the PC SHALL be forced to 00.
REQ-020 PC+4 SHALL be a 32-bit add that wraps modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-021 IF/ID update when stall_D=0:
  - instr_D <= im_ready ? im_rdata : 0x00000000 (nop);
  - pc4_D <= PC+4;
  - valid_D <= im_ready.
  When stall_D=1, all three registers hold.
REQ-022 A redirect SHALL NOT occur while in PEND, because a bubble (valid_D=0) is always in decode at that time; an assertion SHALL check this.
REQ-023 im_addr SHALL be the PC combinationally. im_req SHALL be a register that is 0 in reset and 1 from the first clk edge after reset deasserts.
REQ-024 When stall_D=1 and im_ready=1 in the same cycle, the fetched word is discarded and the same address is refetched.

Reset
REQ-025 While reset=0, the registers SHALL take these values:
  - PC = 0x00003000;
  - pend_target = 0;
  - state = NORMAL;
  - instr_D = 0;
  - pc4_D = 0;
  - valid_D = 0;
  - im_req = 0.
REQ-026 A reset asserted mid-PEND SHALL discard pend_target; the first fetch after reset is at 0x00003000.

Structure
REQ-027 The shared package cpu_pkg SHALL hold PC_RESET (0x00003000), NOP (0), the PCSRC_* encodings and the FSM state type.
REQ-028 The target mux SHALL be one sub-module, npc_sel (pcsrc_D plus three targets in, 32-bit target out). All registers SHALL stay in if_stage.

Verification
REQ-029 Reset release with im_ready=1 -> im_addr sequence 0x3000, 0x3004, 0x3008; pc4_D = 0x3004 one cycle after the first fetch.
REQ-030 Beq in decode with pcsrc_D=1, npcb=0x3040 -> the delay slot at 0x3008 reaches decode with valid_D=1, then im_addr = 0x3040.
REQ-031 Redirect with im_ready=0 for 3 cycles, npcj=0x3100 -> state PEND, valid_D=0 bubbles, the delay slot is fetched when im_ready rises, then im_addr = 0x3100.
REQ-032 stall_D=1 for 2 cycles -> im_addr, instr_D, pc4_D and valid_D are unchanged, and no redirect occurs despite pcsrc_D=3.
REQ-033 jr with npcjr=0x3203 -> im_addr = 0x3200. Reset pulsed during PEND -> im_addr = 0x3000 and state NORMAL.
REQ-034 Run with PC = 0xFFFFFFFC and im_ready=1 -> the next im_addr is 0x00000000.
